// File: rtl/menu_list_ui.sv
// Scrolling menu list: draws a ROWS-high window of NUM_ITEMS entries with a ">" cursor, emits a UUID on enter.
// Latency: nav key to lcd_write_req = 2 cycles; enter key to ui_update = 1 cycle.
// Backpressure: each row write holds lcd_write_req and payload until lcd_ack; keys outside NAV are dropped.
module menu_list_ui #(
    parameter int NUM_ITEMS = 3,
    parameter int ROWS      = 2,
    parameter int WRAP      = 1,
    parameter int UUID_BASE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         active,
    input  logic         key_up,
    input  logic         key_down,
    input  logic         key_enter,
    output logic [3:0]   item_idx,
    input  logic [127:0] item_text,
    output logic         lcd_write_req,
    input  logic         lcd_ack,
    output logic [4:0]   lcd_x_pos,
    output logic [1:0]   lcd_y_pos,
    output logic [127:0] lcd_text,
    output logic [7:0]   lcd_text_len,
    output logic [3:0]   sel_index,
    output logic [3:0]   next_uuid,
    output logic         ui_update
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NAV   = 3'd1,
        LOAD  = 3'd2,
        WRITE = 3'd3,
        ENTER = 3'd4
    } state_t;

    localparam logic [3:0] LAST_ITEM = 4'(NUM_ITEMS - 1);
    localparam logic [3:0] TOP_MAX   = 4'(NUM_ITEMS - ROWS);
    localparam logic [3:0] ROWS_M1   = 4'(ROWS - 1);
    localparam logic [1:0] LAST_ROW  = 2'(ROWS - 1);
    localparam logic [3:0] UUID0     = 4'(UUID_BASE);
    localparam logic [7:0] CHR_CURSOR = 8'h3E;
    localparam logic [7:0] CHR_SPACE  = 8'h20;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] top_q;
    logic [1:0] row_q;
    logic [3:0] row_item;
    logic [3:0] nav_sel;
    logic [3:0] nav_top;
    logic       nav_change;
    logic [7:0] row_marker;

    // The first character of every item is overwritten by the cursor column.
    logic unused_text_hi;
    assign unused_text_hi = ^item_text[127:120];

    // Item currently being drawn: window top plus the row being written.
    assign row_item   = top_q + {2'b00, row_q};
    assign item_idx   = row_item;
    assign row_marker = (row_item == sel_index) ? CHR_CURSOR : CHR_SPACE;

    // Candidate selection/window after an up or down key (up wins over down).
    always_comb begin
        nav_sel = sel_index;
        nav_top = top_q;
        if (key_up) begin
            if (sel_index == 4'd0) begin
                if (WRAP != 0) begin
                    nav_sel = LAST_ITEM;
                    nav_top = TOP_MAX;
                end
            end else begin
                nav_sel = sel_index - 4'd1;
                if (nav_sel < top_q) begin
                    nav_top = nav_sel;
                end
            end
        end else if (key_down) begin
            if (sel_index == LAST_ITEM) begin
                if (WRAP != 0) begin
                    nav_sel = 4'd0;
                    nav_top = 4'd0;
                end
            end else begin
                nav_sel = sel_index + 4'd1;
                if (nav_sel > top_q + ROWS_M1) begin
                    nav_top = nav_sel - ROWS_M1;
                end
            end
        end
        nav_change = (nav_sel != sel_index) || (nav_top != top_q);
    end

    // Next-state logic; dropping active overrides everything.
    always_comb begin
        state_d = state_q;
        if (!active) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = LOAD;
                NAV: begin
                    if (key_enter) begin
                        state_d = ENTER;
                    end else if (nav_change) begin
                        state_d = LOAD;
                    end
                end
                LOAD:  state_d = WRITE;
                WRITE: begin
                    if (lcd_ack) begin
                        state_d = (row_q == LAST_ROW) ? NAV : LOAD;
                    end
                end
                ENTER: state_d = NAV;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Selection, window, row counter, LCD payload and enter pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_index     <= 4'd0;
            top_q         <= 4'd0;
            row_q         <= 2'd0;
            lcd_write_req <= 1'b0;
            lcd_x_pos     <= 5'd0;
            lcd_y_pos     <= 2'd0;
            lcd_text      <= '0;
            lcd_text_len  <= 8'd0;
            next_uuid     <= 4'd0;
            ui_update     <= 1'b0;
        end else begin
            ui_update <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (active) begin
                        sel_index <= 4'd0;
                        top_q     <= 4'd0;
                        row_q     <= 2'd0;
                    end
                end
                NAV: begin
                    if (active) begin
                        if (key_enter) begin
                            next_uuid <= UUID0 + sel_index;
                            ui_update <= 1'b1;
                        end else if (nav_change) begin
                            sel_index <= nav_sel;
                            top_q     <= nav_top;
                            row_q     <= 2'd0;
                        end
                    end
                end
                LOAD: begin
                    if (active) begin
                        lcd_text      <= {row_marker, item_text[119:0]};
                        lcd_x_pos     <= 5'd0;
                        lcd_y_pos     <= row_q;
                        lcd_text_len  <= 8'd16;
                        lcd_write_req <= 1'b1;
                    end
                end
                WRITE: begin
                    if (!active) begin
                        lcd_write_req <= 1'b0;
                    end else if (lcd_ack) begin
                        lcd_write_req <= 1'b0;
                        if (row_q == LAST_ROW) begin
                            row_q <= 2'd0;
                        end else begin
                            row_q <= row_q + 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_menu_list_ui.sv
// Bench for menu_list_ui: scoreboarded LCD writes and enter pulses against a list-level model.
// Latency: checks nav-to-write 2 cycles and enter-to-pulse 1 cycle.
// Backpressure: acks are delayed by a programmable number of cycles, including a 50-cycle stall.
module tb_menu_list_ui;

    localparam int N  = 3;
    localparam int R  = 2;
    localparam int W  = 1;
    localparam int UB = 1;

    logic         clk;
    logic         rst;
    logic         active;
    logic         key_up, key_down, key_enter;
    logic [3:0]   item_idx;
    logic [127:0] item_text;
    logic         lcd_write_req;
    logic         lcd_ack;
    logic [4:0]   lcd_x_pos;
    logic [1:0]   lcd_y_pos;
    logic [127:0] lcd_text;
    logic [7:0]   lcd_text_len;
    logic [3:0]   sel_index;
    logic [3:0]   next_uuid;
    logic         ui_update;

    logic         s_active, s_up, s_down, s_enter;
    logic [3:0]   s_item_idx;
    logic [127:0] s_item_text;
    logic         s_req, s_ack;
    logic [4:0]   s_x;
    logic [1:0]   s_y;
    logic [127:0] s_text;
    logic [7:0]   s_len;
    logic [3:0]   s_sel, s_uuid;
    logic         s_ui;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ack_delay = 3;
    int s_wr_cnt = 0;

    typedef struct { int y; logic [127:0] text; int due; } wr_t;
    typedef struct { logic [3:0] uuid; int due; } ui_t;
    wr_t exp_wr[$];
    ui_t exp_ui[$];
    int  m_sel, m_top;

    function automatic logic [127:0] text_of(input logic [3:0] i);
        logic [127:0] t;
        t = {"XMenu entry ", 8'h30 + {4'h0, i}, "abc"};
        return t;
    endfunction

    function automatic logic [127:0] exp_line(input int idx, input bit selected);
        logic [127:0] t;
        t = text_of(4'(idx));
        t[127:120] = selected ? 8'h3E : 8'h20;
        return t;
    endfunction

    assign item_text   = text_of(item_idx);
    assign s_item_text = text_of(s_item_idx);

    menu_list_ui #(.NUM_ITEMS(N), .ROWS(R), .WRAP(W), .UUID_BASE(UB)) u_dut (
        .clk(clk), .rst(rst), .active(active),
        .key_up(key_up), .key_down(key_down), .key_enter(key_enter),
        .item_idx(item_idx), .item_text(item_text),
        .lcd_write_req(lcd_write_req), .lcd_ack(lcd_ack),
        .lcd_x_pos(lcd_x_pos), .lcd_y_pos(lcd_y_pos), .lcd_text(lcd_text), .lcd_text_len(lcd_text_len),
        .sel_index(sel_index), .next_uuid(next_uuid), .ui_update(ui_update)
    );

    menu_list_ui #(.NUM_ITEMS(N), .ROWS(R), .WRAP(0), .UUID_BASE(UB)) u_sat (
        .clk(clk), .rst(rst), .active(s_active),
        .key_up(s_up), .key_down(s_down), .key_enter(s_enter),
        .item_idx(s_item_idx), .item_text(s_item_text),
        .lcd_write_req(s_req), .lcd_ack(s_ack),
        .lcd_x_pos(s_x), .lcd_y_pos(s_y), .lcd_text(s_text), .lcd_text_len(s_len),
        .sel_index(s_sel), .next_uuid(s_uuid), .ui_update(s_ui)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_redraw(input int due);
        for (int r = 0; r < R; r++) begin
            exp_wr.push_back('{y: r, text: exp_line(m_top + r, (m_top + r) == m_sel), due: (r == 0) ? due : -1});
        end
    endtask

    task automatic model_activate(input int due);
        exp_wr.delete();
        exp_ui.delete();
        m_sel = 0;
        m_top = 0;
        push_redraw(due);
    endtask

    // List-level behaviour: enter > up > down; window scrolls just enough to show the selection.
    task automatic model_key(input logic [2:0] kc, input int k);
        int ns, nt;
        if (kc[2]) begin
            exp_ui.push_back('{uuid: 4'(UB + m_sel), due: k + 1});
        end else if (kc[1] || kc[0]) begin
            if (kc[1]) ns = (m_sel == 0) ? (W != 0 ? N - 1 : 0) : m_sel - 1;
            else       ns = (m_sel == N - 1) ? (W != 0 ? 0 : N - 1) : m_sel + 1;
            nt = m_top;
            if (ns < nt) nt = ns;
            if (ns > nt + R - 1) nt = ns - R + 1;
            if (ns != m_sel || nt != m_top) begin
                m_sel = ns;
                m_top = nt;
                push_redraw(k + 2);
            end
        end
    endtask

    task automatic press(input logic [2:0] kc, input bit noise);
        int n;
        @(negedge clk);
        {key_enter, key_up, key_down} = kc;
        model_key(kc, cyc);
        @(negedge clk);
        {key_enter, key_up, key_down} = 3'b000;
        if (noise) begin
            if (kc[2]) begin
                {key_enter, key_up, key_down} = 3'($urandom_range(1, 7));
                @(negedge clk);
                {key_enter, key_up, key_down} = 3'b000;
            end else begin
                n = 0;
                while (!lcd_write_req && n < 10) begin
                    @(negedge clk);
                    n++;
                end
                if (lcd_write_req) begin
                    {key_enter, key_up, key_down} = 3'($urandom_range(1, 7));
                    @(negedge clk);
                    {key_enter, key_up, key_down} = 3'b000;
                end
            end
        end
    endtask

    task automatic wait_quiet();
        int n, calm;
        n = 0;
        calm = 0;
        while (calm < 3 && n < 2000) begin
            @(negedge clk);
            n++;
            if (exp_wr.size() == 0 && exp_ui.size() == 0 && !lcd_write_req && !ui_update) calm++;
            else calm = 0;
        end
        check("quiet_timeout", 160'(calm >= 3), 160'(1));
    endtask

    task automatic wait_req_high();
        int n;
        n = 0;
        while (!lcd_write_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_rise_timeout", 160'(lcd_write_req), 160'(1));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"}, 160'(lcd_write_req), 0);
        check({tag, "_ui_update"}, 160'(ui_update), 0);
        check({tag, "_next_uuid"}, 160'(next_uuid), 0);
        check({tag, "_item_idx"}, 160'(item_idx), 0);
        check({tag, "_x"}, 160'(lcd_x_pos), 0);
        check({tag, "_y"}, 160'(lcd_y_pos), 0);
        check({tag, "_text"}, 160'(lcd_text), 0);
        check({tag, "_len"}, 160'(lcd_text_len), 0);
        check({tag, "_sel"}, 160'(sel_index), 0);
    endtask

    // LCD driver model for the main instance: ack after ack_delay cycles of request.
    initial begin
        int cnt;
        cnt = 0;
        lcd_ack = 1'b0;
        forever begin
            @(negedge clk);
            lcd_ack = 1'b0;
            if (lcd_write_req) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    lcd_ack = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // LCD driver model and write counter for the saturating instance.
    initial begin
        int cnt;
        logic s_prev;
        cnt = 0;
        s_prev = 1'b0;
        s_ack = 1'b0;
        forever begin
            @(negedge clk);
            s_ack = 1'b0;
            if (s_req && !s_prev) s_wr_cnt++;
            if (s_req) begin
                cnt++;
                if (cnt >= 2) begin
                    s_ack = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
            s_prev = s_req;
        end
    end

    // Monitor: pop the scoreboard on each new write and each enter pulse.
    initial begin
        wr_t e;
        ui_t u;
        logic prev_req, prev_ui;
        logic [127:0] h_text;
        logic [14:0]  h_pos;
        prev_req = 1'b0;
        prev_ui  = 1'b0;
        h_text = '0;
        h_pos  = '0;
        forever begin
            @(negedge clk);
            if (lcd_write_req && !prev_req) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: y=%0d text=%h, no write expected", lcd_y_pos, lcd_text);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_y", 160'(lcd_y_pos), 160'(e.y));
                    check("wr_text", 160'(lcd_text), 160'(e.text));
                    check("wr_x", 160'(lcd_x_pos), 0);
                    check("wr_len", 160'(lcd_text_len), 160'(16));
                    if (e.due >= 0) check("req_latency", 160'(cyc), 160'(e.due));
                end
                h_text = lcd_text;
                h_pos  = {lcd_x_pos, lcd_y_pos, lcd_text_len};
            end else if (lcd_write_req) begin
                check("payload_text_stable", 160'(lcd_text), 160'(h_text));
                check("payload_pos_stable", 160'({lcd_x_pos, lcd_y_pos, lcd_text_len}), 160'(h_pos));
            end
            if (ui_update) begin
                check("ui_pulse_width", 160'(prev_ui), 0);
                if (exp_ui.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ui_update: next_uuid=%0d, no pulse expected", next_uuid);
                end else begin
                    u = exp_ui.pop_front();
                    check("next_uuid", 160'(next_uuid), 160'(u.uuid));
                    check("ui_latency", 160'(cyc), 160'(u.due));
                end
            end
            prev_req = lcd_write_req;
            prev_ui  = ui_update;
        end
    end

    initial begin
        int hi, base;
        rst = 1'b1;
        active = 1'b0;
        {key_enter, key_up, key_down} = 3'b000;
        s_active = 1'b0;
        {s_enter, s_up, s_down} = 3'b000;
        m_sel = 0;
        m_top = 0;

        repeat (3) @(negedge clk);
        check_reset("reset");

        // Power-up draw and then an idle bus.
        @(negedge clk);
        rst = 1'b0;
        active = 1'b1;
        model_activate(cyc + 2);
        wait_quiet();
        check("sel_after_activate", 160'(sel_index), 0);
        repeat (20) @(negedge clk);
        check("idle_no_req", 160'(lcd_write_req), 0);

        // Scroll down twice, wrap down to 0, wrap up to last, step up.
        press(3'b001, 0); wait_quiet(); check("sel_down1", 160'(sel_index), 160'(m_sel));
        press(3'b001, 0); wait_quiet(); check("sel_down2", 160'(sel_index), 160'(2));
        press(3'b001, 0); wait_quiet(); check("sel_wrap_to_0", 160'(sel_index), 160'(0));
        press(3'b010, 0); wait_quiet(); check("sel_wrap_to_last", 160'(sel_index), 160'(2));
        press(3'b010, 0); wait_quiet(); check("sel_up", 160'(sel_index), 160'(1));

        // Enter alone, then enter together with down.
        press(3'b100, 0); wait_quiet();
        press(3'b101, 0); wait_quiet();
        check("sel_after_enter_down", 160'(sel_index), 160'(1));

        // Long ack stall with a key pressed in the middle of it.
        ack_delay = 50;
        press(3'b001, 0);
        wait_req_high();
        hi = 0;
        while (lcd_write_req && hi < 200) begin
            key_down = (hi == 10);
            hi++;
            @(negedge clk);
        end
        key_down = 1'b0;
        check("stall_req_cycles", 160'(hi), 160'(50));
        ack_delay = 3;
        wait_quiet();
        check("sel_after_stall", 160'(sel_index), 160'(2));

        // Deactivate mid-write, then reactivate from the top of the list.
        press(3'b001, 0);
        wait_req_high();
        active = 1'b0;
        @(negedge clk);
        check("inactive_req_drop", 160'(lcd_write_req), 0);
        exp_wr.delete();
        repeat (5) @(negedge clk);
        check("inactive_no_req", 160'(lcd_write_req), 0);
        active = 1'b1;
        model_activate(cyc + 2);
        wait_quiet();
        check("sel_after_reactivate", 160'(sel_index), 0);

        // Reset pulse mid-write.
        press(3'b001, 0);
        wait_req_high();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("rst_mid_write");
        exp_wr.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_activate(cyc + 2);
        wait_quiet();

        // Random key combinations, random ack delays, keys injected while busy.
        for (int it = 0; it < 40; it++) begin
            ack_delay = $urandom_range(1, 5);
            press(3'($urandom_range(1, 7)), bit'($urandom_range(0, 1)));
            wait_quiet();
            check("rand_sel", 160'(sel_index), 160'(m_sel));
        end
        check("wr_queue_empty", 160'(exp_wr.size()), 0);
        check("ui_queue_empty", 160'(exp_ui.size()), 0);

        // Saturating instance: no movement past either end, no LCD traffic.
        s_active = 1'b1;
        repeat (30) @(negedge clk);
        check("sat_initial_writes", 160'(s_wr_cnt), 160'(2));
        check("sat_sel_init", 160'(s_sel), 0);
        base = s_wr_cnt;
        @(negedge clk); s_up = 1'b1;
        @(negedge clk); s_up = 1'b0;
        repeat (20) @(negedge clk);
        check("sat_up_no_write", 160'(s_wr_cnt - base), 0);
        check("sat_up_sel", 160'(s_sel), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); s_down = 1'b1;
            @(negedge clk); s_down = 1'b0;
            repeat (30) @(negedge clk);
        end
        check("sat_sel_last", 160'(s_sel), 160'(2));
        base = s_wr_cnt;
        @(negedge clk); s_down = 1'b1;
        @(negedge clk); s_down = 1'b0;
        repeat (20) @(negedge clk);
        check("sat_down_no_write", 160'(s_wr_cnt - base), 0);
        check("sat_down_sel", 160'(s_sel), 160'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/menu_list_ui.md
MENU_LIST_UI -- requirements
Module: menu_list_ui

Interface
REQ-001 SHALL have parameter NUM_ITEMS, default 3, meaning number of selectable menu items (2..15).
REQ-002 SHALL have parameter ROWS, default 2, meaning number of visible LCD rows (1..4, ROWS <= NUM_ITEMS).
REQ-003 SHALL have parameter WRAP, default 1, meaning 1 = UP/DOWN wrap at list ends, 0 = saturate.
REQ-004 SHALL have parameter UUID_BASE, default 1, meaning UUID emitted for item 0; item i emits UUID_BASE+i.
REQ-005 Port: clk  in  1  system clock; all logic on rising edge.
REQ-006 Port: rst  in  1  reset, asynchronous, active-high.
REQ-007 Port: active  in  1  block enabled; low forces IDLE.
REQ-008 Port: key_up, key_down, key_enter  in  1 each  single-cycle decoded key pulses.
REQ-009 Port: item_idx  out  4  index of item whose text is requested.
REQ-010 Port: item_text  in  128  16-char ASCII text of item item_idx, combinational, valid same cycle.
REQ-011 Port: lcd_write_req  out  1  write request, held until acknowledged.
REQ-012 Port: lcd_ack  in  1  single-cycle write acknowledge from LCD driver.
REQ-013 Port: lcd_x_pos out 5, lcd_y_pos out 2, lcd_text out 128, lcd_text_len out 8  write payload.
REQ-014 Port: sel_index  out  4  currently selected item.
REQ-015 Port: next_uuid  out  4  target UI on enter; ui_update  out  1  single-cycle navigate pulse.

Function
REQ-016 States SHALL be IDLE, NAV, LOAD, WRITE, ENTER.
REQ-017 IDLE -> LOAD when active; sel_index=0, top=0, row counter r=0.
REQ-018 LOAD (1 cycle): item_idx=top+r; latch lcd_text=item_text with byte[127:120] replaced by ">" if top+r==sel_index else " "; lcd_x_pos=0, lcd_y_pos=r, lcd_text_len=16; -> WRITE.
REQ-019 WRITE: lcd_write_req=1 until the cycle lcd_ack=1; on ack deassert next cycle; r<ROWS-1 -> r+1, LOAD; else r=0, NAV.
REQ-020 Payload SHALL remain stable while lcd_write_req=1.
REQ-021 NAV: key_up decrements sel_index, key_down increments; at 0/NUM_ITEMS-1 wrap (WRAP=1) or hold (WRAP=0).
REQ-022 Window: if new sel_index<top then top=sel_index; if new sel_index>top+ROWS-1 then top=sel_index-ROWS+1; wrap to 0 sets top=0, wrap to last sets top=NUM_ITEMS-ROWS.
REQ-023 Any sel_index or top change SHALL cause NAV -> LOAD (full redraw, r=0); no change = no LCD traffic (no periodic refresh).
REQ-024 key_enter in NAV -> ENTER; ENTER (1 cycle): next_uuid=UUID_BASE+sel_index, ui_update=1; -> NAV.
REQ-025 Priority when simultaneous in NAV: key_enter > key_up > key_down; lower-priority pulses dropped.
REQ-026 Keys arriving in LOAD/WRITE/ENTER SHALL be ignored (not queued).
REQ-027 active falling during WRITE: lcd_write_req drops next cycle, state -> IDLE; sel_index reset to 0 on next activation.
REQ-028 Arithmetic on sel_index/top SHALL be 4-bit unsigned with no overflow for legal parameters.
REQ-029 Latency: key pulse in NAV to lcd_write_req high = 2 cycles; enter pulse to ui_update = 1 cycle.

Reset
REQ-030 On rst: state=IDLE, sel_index=0, top=0, r=0, lcd_write_req=0, ui_update=0, next_uuid=0, item_idx=0, lcd_x_pos=0, lcd_y_pos=0, lcd_text=0, lcd_text_len=0.
REQ-031 rst asserted mid-write SHALL drop lcd_write_req immediately (asynchronously).

Verification
REQ-032 Defaults, active=1, ack 3 cycles after each req -> two writes: y=0 ">"+item0, y=1 " "+item1, then idle bus.
REQ-033 NUM_ITEMS=3, ROWS=2, two key_down -> sel=2, top=1; redraw y=0 " "+item1, y=1 ">"+item2.
REQ-034 WRAP=1, sel=0, key_up -> sel=2, top=1; WRAP=0 same stimulus -> sel=0, no LCD write.
REQ-035 sel=1, key_enter -> next_uuid=2, ui_update high exactly 1 cycle; key_enter+key_down same cycle -> enter only, sel unchanged.
REQ-036 lcd_ack withheld 50 cycles -> lcd_write_req and payload stable 50 cycles; key_down during wait ignored.
REQ-037 rst pulse during WRITE -> lcd_write_req low same cycle, all outputs at REQ-030 values.
